// File: rtl/fetch_resp_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_resp_unit_pkg
// Brief    : Shared constants and state encoding for the fetch response unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_resp_unit_pkg;

  // Virtual PC presented before the first packet has been fetched.
  localparam logic [31:0] C_PC_RESET    = 32'h1c00_0000;
  // 32-bit beats per fetch packet (two instructions).
  localparam int          C_FETCH_BEATS = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_resp_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_resp_if
// Brief    : IF0/IF1 request-response handshake plus the burst read bus.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_resp_if
  import fetch_resp_unit_pkg::*;
#(
  parameter int BEATS = C_FETCH_BEATS
);

  // IF0 request side
  logic                  rvalid;
  logic [31:0]           raddr;
  logic [31:0]           p_addr;
  logic                  addr_ok;
  logic                  flush;
  // IF1 response side
  logic                  resp_ack;
  logic                  rready;
  logic [BEATS*32-1:0]   rdata;
  logic [31:0]           resp_pc;
  // Burst read bus
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  mem_rlast;

  // The fetch response unit itself.
  modport slave (
    input  rvalid, raddr, p_addr, flush, resp_ack,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    output addr_ok, rready, rdata, resp_pc, mem_req, mem_addr
  );

  // Pipeline plus memory bridge surrounding the unit.
  modport master (
    output rvalid, raddr, p_addr, flush, resp_ack,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    input  addr_ok, rready, rdata, resp_pc, mem_req, mem_addr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_resp_unit_beat_assembler.sv
`default_nettype none
// ============================================================================
// Module   : fetch_beat_assembler
// Brief    : Beat counter and packet register; packs 32-bit read beats into
//            one fetch packet, beat 0 in the low word.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_beat_assembler #(
  parameter int BEATS = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                beat_valid,
  input  logic [31:0]         beat_data,
  input  logic                clear,
  output logic [BEATS*32-1:0] packet,
  output logic                done
);

  localparam int              CNT_W      = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] C_BEAT_MAX = CNT_W'(BEATS);

  logic [CNT_W-1:0]    r_cnt;
  logic [BEATS*32-1:0] r_packet;

  // Store each beat in its slot; surplus beats are dropped and the count saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_packet <= '0;
    end else if (clear) begin
      r_cnt    <= '0;
    end else if (beat_valid && (r_cnt < C_BEAT_MAX)) begin
      r_packet[32*r_cnt +: 32] <= beat_data;
      r_cnt                    <= r_cnt + CNT_W'(1);
    end
  end

  assign packet = r_packet;
  assign done   = (r_cnt == C_BEAT_MAX);

endmodule
`default_nettype wire

// File: rtl/fetch_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_resp_unit
// Brief    : IF0->IF1 fetch responder. Accepts one request, reads an aligned
//            BEATS*32-bit packet over the burst bus and holds it for IF1;
//            flush drops or drains the in-flight transaction.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_resp_unit
  import fetch_resp_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = C_PC_RESET,
  parameter int          BEATS    = C_FETCH_BEATS
) (
  input  logic        clk,
  input  logic        rstn,
  fetch_resp_if.slave bus
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic        r_rready;
  logic        r_mem_req;
  logic [31:0] r_resp_pc;
  logic [31:0] r_mem_addr;

  logic w_addr_ok;
  logic w_last_beat;
  logic w_beat_clear;
  logic w_beat_write;
  logic w_unused_pkt_done;
  logic w_unused_paddr_lsb;

  assign w_addr_ok    = (r_state == IDLE) && bus.rvalid && !bus.flush;
  assign w_last_beat  = bus.mem_rvalid && bus.mem_rlast;
  assign w_beat_clear = (r_state == ADDR) && bus.mem_gnt;
  // A flush kills the transaction, so a beat arriving with it is not kept.
  assign w_beat_write = (r_state == DATA) && bus.mem_rvalid && !bus.flush;

  // Packet completion is signalled by rlast, not by the beat count.
  assign w_unused_paddr_lsb = ^bus.p_addr[2:0];

  fetch_beat_assembler #(
    .BEATS (BEATS)
  ) u_beat_assembler (
    .clk        (clk),
    .rstn       (rstn),
    .beat_valid (w_beat_write),
    .beat_data  (bus.mem_rdata),
    .clear      (w_beat_clear),
    .packet     (bus.rdata),
    .done       (w_unused_pkt_done)
  );

  // Next-state decode of the transaction FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_addr_ok) w_next = ADDR;
      end
      ADDR: begin
        if (bus.mem_gnt)    w_next = bus.flush ? DISCARD : DATA;
        else if (bus.flush) w_next = IDLE;
      end
      DATA: begin
        if (bus.flush)        w_next = w_last_beat ? IDLE : DISCARD;
        else if (w_last_beat) w_next = HOLD;
      end
      HOLD: begin
        if (bus.flush || bus.resp_ack) w_next = IDLE;
      end
      DISCARD: begin
        if (w_last_beat) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered rready / mem_req decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rready  <= 1'b0;
      r_mem_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rready  <= (w_next == HOLD);
      r_mem_req <= (w_next == ADDR);
    end
  end

  // Capture PC and aligned burst address when a request is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_pc  <= PC_RESET;
      r_mem_addr <= 32'h0;
    end else if (w_addr_ok) begin
      r_resp_pc  <= bus.raddr;
      r_mem_addr <= {bus.p_addr[31:3], 3'b000};
    end
  end

  assign bus.addr_ok  = w_addr_ok;
  assign bus.rready   = r_rready;
  assign bus.resp_pc  = r_resp_pc;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_resp_unit
// Brief    : Self-checking bench for fetch_resp_unit; transaction-level
//            reference with directed and randomized fetches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_resp_unit;

  localparam int          BEATS    = 2;
  localparam logic [31:0] PC_RESET = 32'h1c00_0000;

  // Where a transaction is killed.
  localparam int F_NONE = 0;  // completes normally
  localparam int F_ADDR = 1;  // flush while waiting for grant
  localparam int F_GNT  = 2;  // flush together with grant
  localparam int F_DATA = 3;  // flush in a gap after beat 0
  localparam int F_LAST = 4;  // flush together with the last beat
  localparam int F_HOLD = 5;  // flush while the packet is held

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [BEATS*32-1:0] exp_pkt;
  logic [31:0]         exp_pc;
  logic [31:0]         exp_maddr;

  fetch_resp_if #(.BEATS(BEATS)) bus ();

  fetch_resp_unit #(
    .PC_RESET (PC_RESET),
    .BEATS    (BEATS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rvalid     = 1'b0;
    bus.raddr      = 32'h0;
    bus.p_addr     = 32'h0;
    bus.flush      = 1'b0;
    bus.resp_ack   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_rlast  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rready"},   bus.rready,   0);
    check_eq({tag, "_mem_req"},  bus.mem_req,  0);
    check_eq({tag, "_rdata"},    bus.rdata,    0);
    check_eq({tag, "_resp_pc"},  bus.resp_pc,  PC_RESET);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
  endtask

  // One complete fetch transaction; expected values follow the protocol rules.
  task automatic run_txn(input logic [31:0] pc, input logic [31:0] pa, input bit preamble,
                         input int gnt_wait, input int mode, input int nbeats,
                         input int max_gap, input int hold_wait, input bit hold_ack,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] beat_d [3];
    bit          killed;
    int          gap;
    beat_d[0] = d0;
    beat_d[1] = d1;
    beat_d[2] = d2;

    // A request presented with flush is refused and nothing starts.
    if (preamble) begin
      bus.rvalid = 1'b1; bus.raddr = $urandom; bus.p_addr = $urandom; bus.flush = 1'b1;
      #1;
      check_eq("addr_ok_flush", bus.addr_ok, 0);
      tick();
      bus.flush = 1'b0;
      check_eq("mem_req_refused", bus.mem_req, 0);
    end

    bus.rvalid = 1'b1; bus.raddr = pc; bus.p_addr = pa; bus.flush = 1'b0;
    #1;
    check_eq("addr_ok", bus.addr_ok, 1);
    check_eq("rready_idle", bus.rready, 0);
    exp_pc    = pc;
    exp_maddr = {pa[31:3], 3'b000};
    tick();
    bus.rvalid = 1'b0;
    check_eq("mem_req_addr", bus.mem_req, 1);
    check_eq("mem_addr", bus.mem_addr, exp_maddr);
    check_eq("resp_pc_latch", bus.resp_pc, exp_pc);

    repeat (gnt_wait) begin
      bus.mem_gnt = 1'b0;
      tick();
      check_eq("mem_req_wait", bus.mem_req, 1);
      check_eq("mem_addr_stable", bus.mem_addr, exp_maddr);
    end

    if (mode == F_ADDR) begin
      bus.flush = 1'b1; bus.mem_gnt = 1'b0;
      tick();
      bus.flush = 1'b0;
      check_eq("mem_req_after_addr_flush", bus.mem_req, 0);
      check_eq("rready_after_addr_flush", bus.rready, 0);
      return;
    end

    bus.mem_gnt = 1'b1; bus.flush = (mode == F_GNT);
    tick();
    bus.mem_gnt = 1'b0; bus.flush = 1'b0;
    killed = (mode == F_GNT);
    check_eq("mem_req_data", bus.mem_req, 0);

    for (int i = 0; i < nbeats; i++) begin
      gap = $urandom_range(max_gap, 0);
      if (mode == F_DATA && i == 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        bus.mem_rvalid = 1'b0;
        if (mode == F_DATA && i == 1 && g == 0) begin
          bus.flush = 1'b1;
          killed    = 1'b1;
        end else begin
          bus.flush = killed && ($urandom_range(1, 0) == 1);
        end
        tick();
        bus.flush = 1'b0;
        check_eq("rready_gap", bus.rready, 0);
        check_eq("mem_req_gap", bus.mem_req, 0);
        check_eq("rdata_gap", bus.rdata, exp_pkt);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beat_d[i];
      bus.mem_rlast  = (i == nbeats - 1);
      if (mode == F_LAST && i == nbeats - 1) begin
        bus.flush = 1'b1;
        killed    = 1'b1;
      end else begin
        bus.flush = killed && ($urandom_range(1, 0) == 1);
      end
      if (!killed && i < BEATS) exp_pkt[i*32 +: 32] = beat_d[i];
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0; bus.flush = 1'b0;
      check_eq("rdata_beat", bus.rdata, exp_pkt);
      if (i != nbeats - 1) begin
        check_eq("rready_beat", bus.rready, 0);
        check_eq("mem_req_beat", bus.mem_req, 0);
      end
    end

    if (killed) begin
      check_eq("rready_killed", bus.rready, 0);
      check_eq("mem_req_killed", bus.mem_req, 0);
      return;
    end

    check_eq("rready_hold", bus.rready, 1);
    check_eq("rdata_hold", bus.rdata, exp_pkt);
    check_eq("resp_pc_hold", bus.resp_pc, exp_pc);

    for (int h = 0; h < hold_wait; h++) begin
      bus.resp_ack = 1'b0;
      bus.rvalid   = $urandom_range(1, 0);
      bus.raddr    = $urandom;
      bus.p_addr   = $urandom;
      #1;
      check_eq("addr_ok_hold", bus.addr_ok, 0);
      tick();
      check_eq("rready_bp", bus.rready, 1);
      check_eq("rdata_bp", bus.rdata, exp_pkt);
      check_eq("resp_pc_bp", bus.resp_pc, exp_pc);
      check_eq("mem_req_bp", bus.mem_req, 0);
    end

    bus.rvalid   = 1'b1;
    bus.resp_ack = (mode == F_HOLD) ? hold_ack : 1'b1;
    bus.flush    = (mode == F_HOLD);
    #1;
    check_eq("addr_ok_ack_cycle", bus.addr_ok, 0);
    tick();
    bus.rvalid = 1'b0; bus.resp_ack = 1'b0; bus.flush = 1'b0;
    check_eq("rready_after_ack", bus.rready, 0);
  endtask

  initial begin
    idle_inputs();
    exp_pkt = '0;

    repeat (2) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Zero-wait fetch with five cycles of back-pressure.
    run_txn(32'h1c00_0010, 32'h0000_0014, 1'b0, 0, F_NONE, 2, 0, 5, 1'b0,
            32'h1111_1111, 32'h2222_2222, 32'h0);
    check_eq("zero_wait_packet", bus.rdata, 64'h2222_2222_1111_1111);
    check_eq("zero_wait_pc", bus.resp_pc, 32'h1c00_0010);

    // Flush in ADDR without grant, then flush coincident with grant.
    run_txn(32'h1c00_0100, 32'h0000_2008, 1'b0, 1, F_ADDR, 2, 0, 0, 1'b0,
            32'h0, 32'h0, 32'h0);
    run_txn(32'h1c00_0200, 32'h0000_3000, 1'b0, 0, F_GNT, 2, 0, 0, 1'b0,
            32'hdead_0001, 32'hdead_0002, 32'h0);
    check_eq("gnt_flush_packet", bus.rdata, 64'h2222_2222_1111_1111);

    // Flush in DATA after beat 0: upper word keeps its old value.
    run_txn(32'h1c00_0300, 32'h0000_4000, 1'b0, 0, F_DATA, 2, 0, 0, 1'b0,
            32'h3333_3333, 32'h4444_4444, 32'h0);
    check_eq("data_flush_packet", bus.rdata, 64'h2222_2222_3333_3333);

    // Flush and ack together in HOLD, flush on last beat, surplus beat.
    run_txn(32'h1c00_0400, 32'h0000_5004, 1'b1, 2, F_HOLD, 2, 1, 1, 1'b1,
            32'h5555_5555, 32'h6666_6666, 32'h0);
    run_txn(32'h1c00_0500, 32'h0000_6000, 1'b0, 0, F_LAST, 2, 1, 0, 1'b0,
            32'h7777_7777, 32'h8888_8888, 32'h0);
    run_txn(32'h1c00_0600, 32'h0000_7000, 1'b0, 0, F_NONE, 3, 0, 0, 1'b0,
            32'h9999_9999, 32'haaaa_aaaa, 32'hbbbb_bbbb);
    check_eq("surplus_beat_packet", bus.rdata, 64'haaaa_aaaa_9999_9999);

    for (int n = 0; n < 150; n++) begin
      run_txn($urandom, $urandom, 1'($urandom_range(1, 0)), $urandom_range(2, 0),
              $urandom_range(5, 0), $urandom_range(3, 2), $urandom_range(2, 0),
              $urandom_range(3, 0), 1'($urandom_range(1, 0)),
              $urandom, $urandom, $urandom);
    end

    // Asynchronous reset while in DATA.
    bus.rvalid = 1'b1; bus.raddr = 32'h1c00_0800; bus.p_addr = 32'h0000_8000;
    tick();
    bus.rvalid = 1'b0; bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hcccc_cccc;
    tick();
    bus.mem_rvalid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bus.rvalid = 1'b1;
    #1;
    check_eq("addr_ok_in_reset", bus.addr_ok, 1);
    bus.rvalid = 1'b0;
    tick();
    check_reset_outputs("reset_held");
    #3;
    rstn = 1'b1;
    exp_pkt = '0;
    tick();
    run_txn(32'h1c00_0900, 32'h0000_9000, 1'b0, 0, F_NONE, 2, 0, 1, 1'b0,
            32'h0123_4567, 32'h89ab_cdef, 32'h0);
    check_eq("post_reset_packet", bus.rdata, 64'h89ab_cdef_0123_4567);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
